dsp_ctrl_wb: RTL and testbench
==============================

DSP_CTRL_WB -- requirements
Module: dsp_ctrl_wb

Interface
REQ-001 SHALL have parameter ROWS, default `HW_DSP_PE_ROWS, the PE rows per output word.
REQ-002 SHALL have parameter BP_ACT_BUF_DEPTH, default `HW_BP_ACT_BUF_DEPTH, the CIJ counter width.
REQ-003 SHALL have parameter BP_OUT_BUF_DEPTH, default `HW_BP_OUT_BUF_DEPTH, the output-buffer address width.
REQ-004 SHALL have parameter OUT_W, default 32*ROWS, the output-buffer word width.
REQ-005 SHALL have parameter RD_LAT, default 2, the output-buffer read latency in cycles.
REQ-006 Ports; one clock; reset is asynchronous and active-high:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- bp_subtile_K  in  8  K subtile; sampled at start
- bp_subtile_HW  in  8  HW subtile; sampled at start
- bp_subtile_CIJ  in  BP_ACT_BUF_DEPTH  CIJ subtile; sampled at start
- bp_opt_subtile_HWCIJ  in  BP_ACT_BUF_DEPTH+8  HW*CIJ; sampled at start
- bp_wb_tile_start  in  1  start pulse
- bp_out_buf_wb_rd_en  out  1  output-buffer read enable
- bp_out_buf_wb_addr  out  BP_OUT_BUF_DEPTH  output-buffer read address
- bp_out_buf_wb_rdata  in  OUT_W  read data, valid RD_LAT cycles after rd_en
- bp_wb_data  out  OUT_W  stream data
- bp_wb_valid  out  1  stream valid
- bp_wb_ready  in  1  stream ready
- bp_wb_last  out  1  final beat of the tile
- bp_wb_busy  out  1  high when not IDLE
- bp_wb_tile_end  out  1  one-cycle completion pulse

Function
REQ-007 SHALL implement states IDLE, ISSUE and DRAIN.
REQ-008 From IDLE, bp_wb_tile_start SHALL latch all four sizes and enter ISSUE; start SHALL be ignored in ISSUE and DRAIN.
REQ-009 SHALL read the final accumulated psum per (k,hw) at address k*HWCIJ + hw*CIJ + (CIJ-1), truncated to BP_OUT_BUF_DEPTH bits.
REQ-010 Read order SHALL be k outer (0..K-1) and hw inner (0..HW-1), giving K*HW beats per tile.
REQ-011 Address and rd_en SHALL be registered, with the address valid in the same cycle rd_en is high.
REQ-012 A read SHALL issue in ISSUE only when fifo_count + inflight < 4 (credit rule), so data is never dropped under backpressure.
REQ-013 Returned data SHALL enter a 4-entry FIFO; bp_wb_data and bp_wb_valid SHALL be driven from the FIFO head.
REQ-014 A beat SHALL transfer on valid & ready; once asserted, valid and data SHALL hold until the transfer.
REQ-015 bp_wb_last SHALL be high with valid on beat K*HW-1 only.
REQ-016 ISSUE SHALL go to DRAIN in the cycle after the last read issues.
REQ-017 DRAIN SHALL go to IDLE when the last beat transfers, with bp_wb_tile_end high for exactly that next cycle.
REQ-018 If K, HW or CIJ is 0 at start, the block SHALL issue no reads, produce no beats, pulse bp_wb_tile_end one cycle after start and return to IDLE.
REQ-019 With ready held high, throughput SHALL be 1 beat/cycle, and the first valid SHALL appear RD_LAT+2 cycles after start.
REQ-020 A FIFO push and pop in the same cycle SHALL leave fifo_count unchanged.

Reset
REQ-021 rst SHALL asynchronously force the following, including mid-tile:
- state IDLE
- counters, inflight and FIFO pointers 0
- rd_en, valid, last, busy and tile_end 0
- addr and data 0
REQ-022 Read data returning after reset deasserts from reads issued before reset SHALL be discarded, tracked by a valid pipeline of RD_LAT bits that reset clears.

Structure
REQ-023 State enum wb_state_t and FIFO depth constant WB_FIFO_DEPTH=4 SHALL live in the shared package with the existing HW_ defines.
REQ-024 The FIFO SHALL be a sub-module wb_fifo (parameters WIDTH, DEPTH) with push/pop/full/empty/count ports; the address generation and FSM stay in dsp_ctrl_wb.

Verification
REQ-025 K=2, HW=3, CIJ=4, HWCIJ=12, ready=1 -> address sequence 3,7,11,15,19,23; 6 beats with last on beat 6; tile_end one cycle after beat 6.
REQ-026 Same sizes with ready toggling 1,0,0,1 repeating -> no lost or duplicated beats, data order matches the address order, and the FIFO never exceeds 4 entries.
REQ-027 K=0 -> no rd_en, no valid, tile_end pulse one cycle after start.
REQ-028 K=1, HW=1, CIJ=1 -> single read at address 0; one beat with last=1.
REQ-029 rst asserted after 3 beats of a 6-beat tile, then a new start -> all outputs 0 during reset, no stale beats, and the new tile completes correctly.
REQ-030 Start pulsed again in ISSUE and in DRAIN -> ignored; beat count stays K*HW.

Source files
------------

// File: rtl/dsp_ctrl_wb_pkg.sv
// Shared definitions for the DSP write-back controller: build-time sizes,
// FSM state type and FIFO depth.
`ifndef HW_DSP_PE_ROWS
`define HW_DSP_PE_ROWS 4
`endif
`ifndef HW_BP_ACT_BUF_DEPTH
`define HW_BP_ACT_BUF_DEPTH 10
`endif
`ifndef HW_BP_OUT_BUF_DEPTH
`define HW_BP_OUT_BUF_DEPTH 10
`endif

package dsp_ctrl_wb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } wb_state_t;

  localparam int unsigned WB_FIFO_DEPTH = 4;
  localparam int unsigned WB_CNT_W      = $clog2(WB_FIFO_DEPTH + 1);

endpackage

// File: rtl/dsp_ctrl_wb_fifo.sv
// Small synchronous FIFO buffering output-buffer read data ahead of the
// write-back stream; head entry is presented combinationally.
module wb_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full     = (cnt == CW'(DEPTH));
    empty    = (cnt == '0);
    count    = cnt;
    pop_data = mem[rd_ptr];
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dsp_ctrl_wb.sv
// Write-back controller: walks the output buffer reading the final psum of
// each (k,hw) and streams it out through a credit-limited FIFO.
module dsp_ctrl_wb
  import dsp_ctrl_wb_pkg::*;
#(
  parameter int unsigned ROWS             = `HW_DSP_PE_ROWS,
  parameter int unsigned BP_ACT_BUF_DEPTH = `HW_BP_ACT_BUF_DEPTH,
  parameter int unsigned BP_OUT_BUF_DEPTH = `HW_BP_OUT_BUF_DEPTH,
  parameter int unsigned OUT_W            = 32 * ROWS,
  parameter int unsigned RD_LAT           = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    bp_subtile_K,
  input  logic [7:0]                    bp_subtile_HW,
  input  logic [BP_ACT_BUF_DEPTH-1:0]   bp_subtile_CIJ,
  input  logic [BP_ACT_BUF_DEPTH+7:0]   bp_opt_subtile_HWCIJ,
  input  logic                          bp_wb_tile_start,
  output logic                          bp_out_buf_wb_rd_en,
  output logic [BP_OUT_BUF_DEPTH-1:0]   bp_out_buf_wb_addr,
  input  logic [OUT_W-1:0]              bp_out_buf_wb_rdata,
  output logic [OUT_W-1:0]              bp_wb_data,
  output logic                          bp_wb_valid,
  input  logic                          bp_wb_ready,
  output logic                          bp_wb_last,
  output logic                          bp_wb_busy,
  output logic                          bp_wb_tile_end
);

  localparam int unsigned AW = BP_OUT_BUF_DEPTH;
  localparam int unsigned CW = WB_CNT_W;

  wb_state_t        state_q, state_d;
  logic [7:0]       k_sz, hw_sz, k_cnt, hw_cnt;
  logic [AW-1:0]    cij_step, hwcij_step, row_base, addr_cur;
  logic [15:0]      beats_m1, beat_cnt;
  logic [RD_LAT-1:0] rd_pipe;
  logic [CW-1:0]    inflight, fifo_count;
  logic [CW:0]      occupancy;
  logic             all_issued;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop, rd_return;
  logic [OUT_W-1:0] fifo_head;
  logic             start_zero, load, issue, last_issue, last_pop, tile_end_d;

  logic [7:0]       s_k_sz, s_hw_sz, s_k_cnt, s_hw_cnt;
  logic [AW-1:0]    s_cij, s_hwcij, s_row, s_addr, cij_m1_in;

  always_comb begin
    start_zero = (bp_subtile_K == '0) || (bp_subtile_HW == '0) || (bp_subtile_CIJ == '0);
    rd_return  = rd_pipe[RD_LAT-1];
    fifo_pop   = bp_wb_valid && bp_wb_ready;
    fifo_push  = rd_return && (!fifo_full || fifo_pop);
    // Credit check counts this cycle's pop as freed so a full-rate stream keeps issuing
    occupancy  = (CW+1)'(fifo_count) + (CW+1)'(inflight) - (CW+1)'(fifo_pop);
    last_pop   = fifo_pop && (beat_cnt == beats_m1);
  end

  // Walk operands: the first read issues straight from IDLE using the live inputs
  always_comb begin
    cij_m1_in = AW'(bp_subtile_CIJ) - AW'(1);
    s_k_sz    = load ? bp_subtile_K  : k_sz;
    s_hw_sz   = load ? bp_subtile_HW : hw_sz;
    s_cij     = load ? AW'(bp_subtile_CIJ) : cij_step;
    s_hwcij   = load ? AW'(bp_opt_subtile_HWCIJ) : hwcij_step;
    s_row     = load ? cij_m1_in : row_base;
    s_addr    = load ? cij_m1_in : addr_cur;
    s_k_cnt   = load ? '0 : k_cnt;
    s_hw_cnt  = load ? '0 : hw_cnt;
    last_issue = (s_k_cnt == s_k_sz - 8'd1) && (s_hw_cnt == s_hw_sz - 8'd1);
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    issue      = 1'b0;
    tile_end_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bp_wb_tile_start) begin
          if (start_zero) begin
            tile_end_d = 1'b1;
          end else begin
            load    = 1'b1;
            issue   = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (all_issued) state_d = DRAIN;
        else if (occupancy < (CW+1)'(WB_FIFO_DEPTH)) issue = 1'b1;
      end
      DRAIN: begin
        if (last_pop) begin
          state_d    = IDLE;
          tile_end_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_sz                <= '0;
      hw_sz               <= '0;
      k_cnt               <= '0;
      hw_cnt              <= '0;
      cij_step            <= '0;
      hwcij_step          <= '0;
      row_base            <= '0;
      addr_cur            <= '0;
      beats_m1            <= '0;
      beat_cnt            <= '0;
      rd_pipe             <= '0;
      inflight            <= '0;
      all_issued          <= 1'b0;
      bp_out_buf_wb_rd_en <= 1'b0;
      bp_out_buf_wb_addr  <= '0;
      bp_wb_tile_end      <= 1'b0;
    end else begin
      bp_wb_tile_end      <= tile_end_d;
      bp_out_buf_wb_rd_en <= issue;
      rd_pipe[0]          <= bp_out_buf_wb_rd_en;
      for (int unsigned i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      inflight <= inflight + CW'(issue) - CW'(rd_return);

      if (load) begin
        k_sz       <= bp_subtile_K;
        hw_sz      <= bp_subtile_HW;
        cij_step   <= AW'(bp_subtile_CIJ);
        hwcij_step <= AW'(bp_opt_subtile_HWCIJ);
        beats_m1   <= 16'(bp_subtile_K) * 16'(bp_subtile_HW) - 16'd1;
        beat_cnt   <= '0;
      end else if (fifo_pop) begin
        beat_cnt <= beat_cnt + 16'd1;
      end

      if (issue) begin
        bp_out_buf_wb_addr <= s_addr;
        all_issued         <= last_issue;
        if (s_hw_cnt == s_hw_sz - 8'd1) begin
          hw_cnt   <= '0;
          k_cnt    <= s_k_cnt + 8'd1;
          row_base <= s_row + s_hwcij;
          addr_cur <= s_row + s_hwcij;
        end else begin
          hw_cnt   <= s_hw_cnt + 8'd1;
          k_cnt    <= s_k_cnt;
          row_base <= s_row;
          addr_cur <= s_addr + s_cij;
        end
      end
    end
  end

  wb_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (WB_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bp_out_buf_wb_rdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    bp_wb_valid = !fifo_empty;
    bp_wb_data  = fifo_empty ? '0 : fifo_head;
    bp_wb_last  = bp_wb_valid && (beat_cnt == beats_m1);
    bp_wb_busy  = (state_q != IDLE);
  end

endmodule

// File: tb/tb_dsp_ctrl_wb.sv
// Directed bench for dsp_ctrl_wb: table of tile shapes and ready patterns,
// plus reset-mid-tile and restart-ignore sequences.
module tb_dsp_ctrl_wb;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  k_in, hw_in;
  logic [9:0]  cij_in;
  logic [17:0] hwcij_in;
  logic        start, ready;
  logic        rd_en;
  logic [9:0]  addr;
  logic [31:0] rdata, data;
  logic        valid, last, busy, tile_end;

  dsp_ctrl_wb #(
    .ROWS             (1),
    .BP_ACT_BUF_DEPTH (10),
    .BP_OUT_BUF_DEPTH (10),
    .OUT_W            (32),
    .RD_LAT           (RD_LAT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .bp_subtile_K         (k_in),
    .bp_subtile_HW        (hw_in),
    .bp_subtile_CIJ       (cij_in),
    .bp_opt_subtile_HWCIJ (hwcij_in),
    .bp_wb_tile_start     (start),
    .bp_out_buf_wb_rd_en  (rd_en),
    .bp_out_buf_wb_addr   (addr),
    .bp_out_buf_wb_rdata  (rdata),
    .bp_wb_data           (data),
    .bp_wb_valid          (valid),
    .bp_wb_ready          (ready),
    .bp_wb_last           (last),
    .bp_wb_busy           (busy),
    .bp_wb_tile_end       (tile_end)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [9:0] a);
    return {16'hC0DE, 6'b0, a};
  endfunction

  // Output buffer model with a two-cycle registered read
  logic [31:0] m1, m2;
  always @(posedge clk) begin
    m1 <= rd_en ? mem_f(addr) : 32'hBAD0_0000;
    m2 <= m1;
  end
  assign rdata = m2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0, n_fail = 0;
  logic [9:0]  addr_q[$];
  logic [31:0] data_q[$];
  logic        last_q[$];
  int          bcyc_q[$], end_q[$];
  int          first_valid, max_out, hold_err;
  bit          busy_seen, prev_stall;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (prev_stall && (!valid || data !== prev_data)) hold_err++;
    prev_stall = valid && !ready;
    prev_data  = data;
    if (rd_en) addr_q.push_back(addr);
    if (valid && ready) begin
      data_q.push_back(data);
      last_q.push_back(last);
      bcyc_q.push_back(cyc);
    end
    if (tile_end) end_q.push_back(cyc);
    if (valid && first_valid < 0) first_valid = cyc;
    if (busy) busy_seen = 1'b1;
    if (int'(addr_q.size()) - int'(data_q.size()) > max_out)
      max_out = int'(addr_q.size()) - int'(data_q.size());
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    addr_q.delete(); data_q.delete(); last_q.delete(); bcyc_q.delete(); end_q.delete();
    first_valid = -1; max_out = 0; hold_err = 0; busy_seen = 1'b0; prev_stall = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_rd_en"}, rd_en, 0);
    chk({pfx, "_addr"}, addr, 0);
    chk({pfx, "_valid"}, valid, 0);
    chk({pfx, "_data"}, data, 0);
    chk({pfx, "_last"}, last, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_tile_end"}, tile_end, 0);
  endtask

  typedef struct {
    logic [7:0]  k, hw;
    logic [9:0]  cij;
    logic [17:0] hwcij;
    logic [3:0]  rdy;
    bit          restart;
    int          exp_beats;
    logic [9:0]  exp_first, exp_last;
  } vec_t;

  task automatic run_tile(input vec_t v, input int id);
    int  s, n;
    bit  done;
    logic [9:0] ea;
    string t;
    t = $sformatf("v%0d", id);
    clear_mon();
    @(posedge clk); #1;
    k_in = v.k; hw_in = v.hw; cij_in = v.cij; hwcij_in = v.hwcij;
    start = 1'b1; s = cyc; ready = v.rdy[0];
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk); #1;
      // sizes are only sampled at start; scramble them afterwards
      k_in = 8'd7; hw_in = 8'd5; cij_in = 10'd9; hwcij_in = 18'd45;
      start = v.restart && (cyc == s + 2 || cyc == s + 8);
      ready = v.rdy[(cyc - s) % 4];
      if (end_q.size() > 0) done = 1'b1;
    end
    chk({t, "_tile_end_seen"}, done, 1);
    ready = 1'b1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n = v.exp_beats;
    chk({t, "_reads"}, addr_q.size(), n);
    chk({t, "_beats"}, data_q.size(), n);
    chk({t, "_tile_end_pulses"}, end_q.size(), 1);
    chk({t, "_busy_after"}, busy, 0);
    chk({t, "_hold"}, hold_err, 0);
    if (n == 0) begin
      chk({t, "_busy_seen"}, busy_seen, 0);
      if (end_q.size() > 0) chk({t, "_end_cycle"}, end_q[0], s + 1);
    end else begin
      if (addr_q.size() > 0) begin
        chk({t, "_first_addr"}, addr_q[0], v.exp_first);
        chk({t, "_last_addr"}, addr_q[addr_q.size()-1], v.exp_last);
      end
      for (int i = 0; i < n; i++) begin
        ea = 10'((i / int'(v.hw)) * int'(v.hwcij) + (i % int'(v.hw)) * int'(v.cij) + int'(v.cij) - 1);
        if (i < addr_q.size()) chk($sformatf("%s_addr%0d", t, i), addr_q[i], ea);
        if (i < data_q.size()) begin
          chk($sformatf("%s_data%0d", t, i), data_q[i], mem_f(ea));
          chk($sformatf("%s_last%0d", t, i), last_q[i], (i == n - 1));
        end
      end
      chk({t, "_max_outstanding_ok"}, (max_out <= 4), 1);
      if (end_q.size() > 0 && bcyc_q.size() > 0)
        chk({t, "_end_after_last"}, end_q[0], bcyc_q[bcyc_q.size()-1] + 1);
      if (v.rdy == 4'b1111 && bcyc_q.size() > 0) begin
        chk({t, "_first_valid"}, first_valid, s + RD_LAT + 2);
        chk({t, "_full_rate"}, bcyc_q[bcyc_q.size()-1] - bcyc_q[0], n - 1);
      end
    end
  endtask

  vec_t vecs[9];
  vec_t base;

  initial begin
    //          k     hw    cij      hwcij     rdy      rs  beats first   last
    vecs[0] = '{8'd2, 8'd3, 10'd4,   18'd12,  4'b1111, 1, 6,  10'd3,   10'd23};
    vecs[1] = '{8'd2, 8'd3, 10'd4,   18'd12,  4'b1001, 1, 6,  10'd3,   10'd23};
    vecs[2] = '{8'd0, 8'd3, 10'd4,   18'd12,  4'b1111, 0, 0,  10'd0,   10'd0};
    vecs[3] = '{8'd1, 8'd1, 10'd1,   18'd1,   4'b1111, 0, 1,  10'd0,   10'd0};
    vecs[4] = '{8'd2, 8'd0, 10'd4,   18'd0,   4'b1111, 0, 0,  10'd0,   10'd0};
    vecs[5] = '{8'd2, 8'd3, 10'd0,   18'd0,   4'b1111, 0, 0,  10'd0,   10'd0};
    vecs[6] = '{8'd3, 8'd2, 10'd5,   18'd10,  4'b1111, 0, 6,  10'd4,   10'd29};
    vecs[7] = '{8'd2, 8'd2, 10'd300, 18'd600, 4'b0110, 0, 4,  10'd299, 10'd175};
    vecs[8] = '{8'd4, 8'd4, 10'd2,   18'd8,   4'b0011, 0, 16, 10'd1,   10'd31};

    rst = 1'b1; start = 1'b0; ready = 1'b1;
    k_in = '0; hw_in = '0; cij_in = '0; hwcij_in = '0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) run_tile(vecs[i], i);

    // Reset after three beats of a six-beat tile, then a clean rerun
    base = vecs[0];
    base.restart = 0;
    clear_mon();
    @(posedge clk); #1;
    k_in = base.k; hw_in = base.hw; cij_in = base.cij; hwcij_in = base.hwcij;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && data_q.size() < 3; c++) @(negedge clk);
    chk("rst_mid_reached_3_beats", data_q.size(), 3);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("rst_mid");
    @(negedge clk); #1;
    rst = 1'b0;
    clear_mon();
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_stale_reads", addr_q.size(), 0);
    chk("rst_no_stale_beats", data_q.size(), 0);
    chk("rst_idle_busy", busy, 0);
    run_tile(base, 90);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
